// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S frame receiver.
package i2s_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int SC_BITS    = 6;

  localparam logic [SC_BITS-1:0] SC_LAST        = 6'd63;
  localparam logic [SC_BITS-1:0] WS_RIGHT_FIRST = 6'd31;
  localparam logic [SC_BITS-1:0] WS_RIGHT_LAST  = 6'd62;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // ws is raised one SCK ahead of the right slot MSB (Philips alignment)
  function automatic logic ws_for_slot(input logic [SC_BITS-1:0] sc);
    return (sc >= WS_RIGHT_FIRST) && (sc <= WS_RIGHT_LAST);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk by 2*CLK_DIV and flags each SCK edge.
module i2s_sck_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             tc;

  always_comb begin
    tc    = run && (div_q == DIV_LAST);
    div_d = div_q;
    sck_d = sck_q;
    if (!run) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (tc) begin
      div_d = '0;
      sck_d = ~sck_q;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  // Strobes mark the cycle whose closing edge toggles sck
  assign sck  = sck_q;
  assign rise = tc && !sck_q;
  assign fall = tc && sck_q;

endmodule

// File: rtl/i2s_frame_rx.sv
// Master-mode I2S capture: drives SCK/WS and deserializes rx into 64-bit stereo frames.
module i2s_frame_rx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rx,
  output logic                  i2s_clk,
  output logic                  ws,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  frame_valid
);

  state_e                state_q, state_d;
  logic [SC_BITS-1:0]    sc_q, sc_d;
  logic                  primed_q, primed_d;
  logic                  ws_q, ws_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  frame_valid_q, frame_valid_d;
  logic                  pend_q, pend_d;
  logic                  rx_q;
  logic [SC_BITS-1:0]    sc_inc;
  logic                  run, rise, fall;

  assign run    = (state_q == RUN) && en;
  assign sc_inc = sc_q + 1'b1;

  i2s_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk (clk),
    .rst (rst),
    .run (run),
    .sck (i2s_clk),
    .rise(rise),
    .fall(fall)
  );

  always_comb begin
    state_d       = state_q;
    sc_d          = sc_q;
    primed_d      = primed_q;
    ws_d          = ws_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    frame_valid_d = 1'b0;
    pend_d        = 1'b0;

    // A completed frame is published one cycle after its last bit lands
    if (pend_q) begin
      rx_data_d     = shift_q;
      frame_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d  = IDLE;
          sc_d     = SC_LAST;
          primed_d = 1'b0;
          ws_d     = 1'b0;
          shift_d  = '0;
        end else begin
          if (rise) begin
            shift_d = {shift_q[FRAME_BITS-2:0], rx_q};
            pend_d  = (sc_q == SC_LAST) && primed_q;
          end
          if (fall) begin
            sc_d = sc_inc;
            if (sc_q == SC_LAST) primed_d = 1'b1;
            ws_d = ws_for_slot(sc_inc);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sc_q          <= SC_LAST;
      primed_q      <= 1'b0;
      ws_q          <= 1'b0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      frame_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      rx_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      sc_q          <= sc_d;
      primed_q      <= primed_d;
      ws_q          <= ws_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      frame_valid_q <= frame_valid_d;
      pend_q        <= pend_d;
      rx_q          <= rx;
    end
  end

  assign ws          = ws_q;
  assign rx_data     = rx_data_q;
  assign frame_valid = frame_valid_q;

endmodule
